// File: rtl/cr_xp10_decompPKG.sv
// rtl/cr_xp10_decompPKG.sv - shared decompressor types for the lane split block
//
// Purpose: error code enum and 64-bit datapath beat struct used between
// the 128-bit lane splitter and the downstream symbol decoder.
// Ports: none (package).

package cr_xp10_decompPKG;

  localparam int BEAT_BITS = 64;
  localparam int WORD_BITS = 128;

  typedef enum logic [7:0] {
    NO_ERRORS       = 8'h00,
    ERR_HUFF_DECODE = 8'h11,
    ERR_BAD_BLOCK   = 8'h12,
    ERR_OVERRUN     = 8'h13
  } zipline_error_e;

  typedef struct packed {
    logic [63:0]    data;
    logic [7:0]     numbits;
    logic           sob;
    logic           eob;
    logic           eof;
    logic           trace_bit;
    logic           last_frame;
    logic [27:0]    frame_bytes_in;
    zipline_error_e error;
  } lfa_sdd_dp_bus_t;

endpackage

// File: rtl/axi_channel_reg_slice.sv
// rtl/axi_channel_reg_slice.sv - full-handshake register slice (skid buffer)
//
// Purpose: breaks both the valid/data path and the ready path of a channel
// with one output register plus one skid register, sustaining one transfer
// per cycle. Only built when CR_XP10_DECOMP_LANE_SPLIT_OUT_REG_EN is defined,
// since it is the lane splitter's sole optional sub-module.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     upstream handshake (s_ready is a register decode)
//   s_data [WIDTH]      upstream payload
//   m_valid/m_ready     downstream handshake
//   m_data [WIDTH]      downstream payload (registered)

`ifdef CR_XP10_DECOMP_LANE_SPLIT_OUT_REG_EN
module axi_channel_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  // Upstream may push whenever the skid slot is free; the skid absorbs the
  // one beat that arrives in the cycle the downstream first stalls.
  assign s_ready = !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      if (!m_valid || m_ready) begin
        if (skid_valid) begin
          m_valid    <= 1'b1;
          m_data     <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          m_valid <= s_valid;
          if (s_valid) m_data <= s_data;
        end
      end else if (s_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= s_data;
      end
    end
  end

endmodule
`endif

// File: rtl/cr_xp10_decomp_lane_split.sv
// rtl/cr_xp10_decomp_lane_split.sv - splits 128-bit lane words into 64-bit beats
//
// Purpose: accepts one 128-bit lane word with a valid-bit count and emits one
// or two 64-bit beats (two when more than 64 bits are valid). Start-of-block
// goes on the first beat, end flags and the error code on the last beat,
// trace/frame fields on every beat. Back-to-back words stream without bubbles.
// Optional: define CR_XP10_DECOMP_LANE_SPLIT_OUT_REG_EN to register the output
// channel through axi_channel_reg_slice (one extra cycle of latency, in_ready
// no longer combinational from out_ready).
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            input word handshake
//   in_data[128], in_numbits[8]  payload (bit 0 first) and valid bit count
//   in_sob/eob/eof/trace_bit/last_frame, in_frame_bytes_in[28], in_errcode
//   out_valid/out_ready, out_bus output beat handshake and payload
//   stall_stb                    registered strobe: traced beat stalled last cycle

module cr_xp10_decomp_lane_split
  import cr_xp10_decompPKG::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_data,
  input  logic [7:0]      in_numbits,
  input  logic            in_sob,
  input  logic            in_eob,
  input  logic            in_eof,
  input  logic            in_trace_bit,
  input  logic            in_last_frame,
  input  logic [27:0]     in_frame_bytes_in,
  input  zipline_error_e  in_errcode,
  output logic            out_valid,
  output lfa_sdd_dp_bus_t out_bus,
  input  logic            out_ready,
  output logic            stall_stb
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  state_e          state;
  logic            two_beats;
  logic [63:0]     hi_data;
  logic [7:0]      hi_numbits;
  logic            hi_eob;
  logic            hi_eof;
  zipline_error_e  hi_err;

  lfa_sdd_dp_bus_t core_bus;
  logic            core_valid;
  logic            core_ready;

  logic [7:0]      nb_clamped;
  logic            nb_two;
  lfa_sdd_dp_bus_t beat0_bus;
  lfa_sdd_dp_bus_t beat1_bus;
  logic            last_beat;
  logic            accept;
  logic            core_hs;

  always_comb begin
    nb_clamped = (in_numbits > 8'd128) ? 8'd128 : in_numbits;
    nb_two     = (nb_clamped > 8'd64);

    // First beat of the incoming word; end-of-word fields only when it is
    // also the last beat.
    beat0_bus                = '0;
    beat0_bus.data           = in_data[63:0];
    beat0_bus.numbits        = nb_two ? 8'd64 : nb_clamped;
    beat0_bus.sob            = in_sob;
    beat0_bus.eob            = nb_two ? 1'b0 : in_eob;
    beat0_bus.eof            = nb_two ? 1'b0 : in_eof;
    beat0_bus.trace_bit      = in_trace_bit;
    beat0_bus.last_frame     = in_last_frame;
    beat0_bus.frame_bytes_in = in_frame_bytes_in;
    beat0_bus.error          = nb_two ? NO_ERRORS : in_errcode;

    // Second beat built from the held upper half; per-word fields are taken
    // from the beat currently presented, which still carries them.
    beat1_bus                = '0;
    beat1_bus.data           = hi_data;
    beat1_bus.numbits        = hi_numbits;
    beat1_bus.sob            = 1'b0;
    beat1_bus.eob            = hi_eob;
    beat1_bus.eof            = hi_eof;
    beat1_bus.trace_bit      = core_bus.trace_bit;
    beat1_bus.last_frame     = core_bus.last_frame;
    beat1_bus.frame_bytes_in = core_bus.frame_bytes_in;
    beat1_bus.error          = hi_err;
  end

  assign core_valid = (state != EMPTY);
  assign last_beat  = (state == BEAT1) || ((state == BEAT0) && !two_beats);
  // A new word may enter in the same cycle the last beat leaves.
  assign in_ready   = (state == EMPTY) || (last_beat && core_ready);
  assign accept     = in_valid && in_ready;
  assign core_hs    = core_valid && core_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      core_bus   <= '0;
      two_beats  <= 1'b0;
      hi_data    <= '0;
      hi_numbits <= '0;
      hi_eob     <= 1'b0;
      hi_eof     <= 1'b0;
      hi_err     <= NO_ERRORS;
    end else if (accept) begin
      state      <= BEAT0;
      core_bus   <= beat0_bus;
      two_beats  <= nb_two;
      hi_data    <= in_data[127:64];
      hi_numbits <= nb_two ? (nb_clamped - 8'd64) : 8'd0;
      hi_eob     <= in_eob;
      hi_eof     <= in_eof;
      hi_err     <= in_errcode;
    end else if (core_hs) begin
      if ((state == BEAT0) && two_beats) begin
        state    <= BEAT1;
        core_bus <= beat1_bus;
      end else begin
        state    <= EMPTY;
      end
    end
  end

`ifdef CR_XP10_DECOMP_LANE_SPLIT_OUT_REG_EN
  localparam int BUS_W = $bits(lfa_sdd_dp_bus_t);
  logic [BUS_W-1:0] slice_data;

  axi_channel_reg_slice #(
    .WIDTH (BUS_W)
  ) u_out_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (core_valid),
    .s_ready (core_ready),
    .s_data  (core_bus),
    .m_valid (out_valid),
    .m_ready (out_ready),
    .m_data  (slice_data)
  );

  assign out_bus = lfa_sdd_dp_bus_t'(slice_data);
`else
  assign out_valid  = core_valid;
  assign out_bus    = core_bus;
  assign core_ready = out_ready;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_stb <= 1'b0;
    end else begin
      stall_stb <= out_valid && !out_ready && out_bus.trace_bit;
    end
  end

  // Counts above a full word are clamped in the datapath but indicate an
  // upstream bug.
  a_numbits_max : assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready) |-> (in_numbits <= 8'd128));

  // Only the final word of a block/frame may be a short partial word.
  a_partial_final : assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready && (in_numbits != 8'd0) && (in_numbits < 8'd64))
      |-> (in_eob || in_eof));

endmodule

// File: tb/tb_cr_xp10_decomp_lane_split.sv
// tb/tb_cr_xp10_decomp_lane_split.sv - scoreboard bench for the lane splitter

module tb_cr_xp10_decomp_lane_split;
  import cr_xp10_decompPKG::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [127:0]    in_data = '0;
  logic [7:0]      in_numbits = '0;
  logic            in_sob = 1'b0;
  logic            in_eob = 1'b0;
  logic            in_eof = 1'b0;
  logic            in_trace_bit = 1'b0;
  logic            in_last_frame = 1'b0;
  logic [27:0]     in_frame_bytes_in = '0;
  zipline_error_e  in_errcode = NO_ERRORS;
  logic            out_valid;
  lfa_sdd_dp_bus_t out_bus;
  logic            out_ready = 1'b1;
  logic            stall_stb;

  cr_xp10_decomp_lane_split dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_numbits        (in_numbits),
    .in_sob            (in_sob),
    .in_eob            (in_eob),
    .in_eof            (in_eof),
    .in_trace_bit      (in_trace_bit),
    .in_last_frame     (in_last_frame),
    .in_frame_bytes_in (in_frame_bytes_in),
    .in_errcode        (in_errcode),
    .out_valid         (out_valid),
    .out_bus           (out_bus),
    .out_ready         (out_ready),
    .stall_stb         (stall_stb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  lfa_sdd_dp_bus_t exp_q[$];
  int hs_times[$];
  int cyc = 0;

  logic            held_v = 1'b0;
  lfa_sdd_dp_bus_t held_bus = '0;

  function automatic lfa_sdd_dp_bus_t mk(input logic [63:0] d, input logic [7:0] nb,
                                         input logic sob, input logic eob, input logic eof,
                                         input logic tr, input logic lf,
                                         input logic [27:0] fbi, input zipline_error_e er);
    lfa_sdd_dp_bus_t b;
    b.data = d; b.numbits = nb; b.sob = sob; b.eob = eob; b.eof = eof;
    b.trace_bit = tr; b.last_frame = lf; b.frame_bytes_in = fbi; b.error = er;
    return b;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks that a
  // stalled beat stays put until it is taken.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        total++;
        if (!out_valid || (out_bus !== held_bus)) begin
          bad++;
          $display("FAIL hold_stable: got v=%0b %0h expected v=1 %0h", out_valid, out_bus, held_bus);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got %0h expected none", out_bus);
        end else begin
          lfa_sdd_dp_bus_t e;
          e = exp_q.pop_front();
          if (out_bus !== e) begin
            bad++;
            $display("FAIL beat: got %0h expected %0h", out_bus, e);
          end
        end
        hs_times.push_back(cyc);
        held_v = 1'b0;
      end else if (out_valid) begin
        held_v = 1'b1;
        held_bus = out_bus;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_word(input logic [127:0] d, input logic [7:0] nb, input logic sob,
                           input logic eob, input logic eof, input logic tr, input logic lf,
                           input logic [27:0] fbi, input zipline_error_e er);
    bit ok;
    ok = 1'b0;
    in_data = d; in_numbits = nb; in_sob = sob; in_eob = eob; in_eof = eof;
    in_trace_bit = tr; in_last_frame = lf; in_frame_bytes_in = fbi; in_errcode = er;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_drain: got %0d beats pending expected 0", name, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  localparam logic [63:0] LO1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] HI1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] LO2 = 64'hA5A5_0000_1111_2222;
  localparam logic [63:0] HI2 = 64'h3333_4444_5A5A_6666;

  initial begin
    bit saw_valid;

    // Reset state
    #12;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_bus", {{(128-$bits(lfa_sdd_dp_bus_t)){1'b0}}, out_bus}, 128'd0);
    chk("rst_stall", {127'd0, stall_stb}, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // Full word, sob: 64/64, sob on beat 0 only, in_ready low one cycle
    exp_q.push_back(mk(LO1, 8'd64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0000100, NO_ERRORS));
    exp_q.push_back(mk(HI1, 8'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0000100, NO_ERRORS));
    send_word({HI1, LO1}, 8'd128, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0000100, NO_ERRORS);
    chk("full_in_ready_busy", {127'd0, in_ready}, 128'd0);
`ifdef CR_XP10_DECOMP_LANE_SPLIT_OUT_REG_EN
    chk("lat_not_yet", {127'd0, out_valid}, 128'd0);
    @(posedge clk); #1;
    chk("lat_valid", {127'd0, out_valid}, 128'd1);
    chk("full_in_ready_back", {127'd0, in_ready}, 128'd1);
`else
    chk("lat_valid", {127'd0, out_valid}, 128'd1);
    @(posedge clk); #1;
    chk("full_in_ready_back", {127'd0, in_ready}, 128'd1);
`endif
    wait_drain("full");

    // 100 bits, eob, error: 64 then 36; eob/error on beat 1 only
    exp_q.push_back(mk(LO2, 8'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 28'h0ABCDEF, NO_ERRORS));
    exp_q.push_back(mk(HI2, 8'd36, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 28'h0ABCDEF, ERR_BAD_BLOCK));
    send_word({HI2, LO2}, 8'd100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 28'h0ABCDEF, ERR_BAD_BLOCK);
    wait_drain("partial");

    // Zero bits, eof: single beat numbits 0, sob passes through
    exp_q.push_back(mk(LO1, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 28'h0000007, NO_ERRORS));
    send_word({HI1, LO1}, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 28'h0000007, NO_ERRORS);
    wait_drain("empty_word");

    // Back-to-back full words: 4 beats on 4 consecutive cycles, in order
    hs_times.delete();
    exp_q.push_back(mk(LO1, 8'd64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0000200, NO_ERRORS));
    exp_q.push_back(mk(HI1, 8'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0000200, NO_ERRORS));
    exp_q.push_back(mk(LO2, 8'd64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0000300, NO_ERRORS));
    exp_q.push_back(mk(HI2, 8'd64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 28'h0000300, ERR_OVERRUN));
    send_word({HI1, LO1}, 8'd128, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0000200, NO_ERRORS);
    send_word({HI2, LO2}, 8'd128, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 28'h0000300, ERR_OVERRUN);
    wait_drain("b2b");
    chk("b2b_count", 128'(hs_times.size()), 128'd4);
    if (hs_times.size() == 4)
      chk("b2b_span", 128'(hs_times[3] - hs_times[0]), 128'd3);

    // Stall beat 1 of a traced word for 3 cycles
    exp_q.push_back(mk(LO2, 8'd64, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0000400, NO_ERRORS));
    exp_q.push_back(mk(HI2, 8'd64, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0000400, NO_ERRORS));
    send_word({HI2, LO2}, 8'd128, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 28'h0000400, NO_ERRORS);
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid && !out_bus.sob) begin found = 1'b1; break; end
        @(posedge clk); #1;
      end
      chk("stall_beat1_seen", {127'd0, found}, 128'd1);
    end
    out_ready = 1'b0;
    @(negedge clk); chk("stall_d0", {127'd0, stall_stb}, 128'd0);
    @(negedge clk); chk("stall_d1", {127'd0, stall_stb}, 128'd1);
    @(negedge clk); chk("stall_d2", {127'd0, stall_stb}, 128'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk); chk("stall_d3", {127'd0, stall_stb}, 128'd1);
    @(negedge clk); chk("stall_d4", {127'd0, stall_stb}, 128'd0);
    @(posedge clk); #1;
    wait_drain("stall");

    // Reset during BEAT0: everything held is discarded
    send_word({HI1, LO1}, 8'd128, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0000500, NO_ERRORS);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("midrst_no_beat", {127'd0, saw_valid}, 128'd0);
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/cr_xp10_decomp_lane_split.md
CR_XP10_DECOMP_LANE_SPLIT -- requirements
Module: cr_xp10_decomp_lane_split

Interface
REQ-001 SHALL have ports (name  direction  width  meaning): clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have in_valid  in  1  128-bit lane word valid; in_ready  out  1  word accepted when high with in_valid.
REQ-003 SHALL have in_data  in  128  payload, bit 0 first; in_numbits  in  8  valid bits, 0..128.
REQ-004 SHALL have in_sob, in_eob, in_eof, in_trace_bit, in_last_frame  in  1 each  framing flags.
REQ-005 SHALL have in_frame_bytes_in  in  28  frame byte count; in_errcode  in  zipline_error_e  error code.
REQ-006 SHALL have out_valid  out  1; out_bus  out  lfa_sdd_dp_bus_t  64-bit beat; out_ready  in  1.
REQ-007 SHALL have stall_stb  out  1  registered trace stall strobe.

Function
REQ-008 SHALL split each accepted word into N beats: N = ceil(in_numbits/64); N = 1 when in_numbits = 0.
REQ-009 Beat k SHALL carry data = in_data[64k+63:64k] and numbits = min(64, in_numbits-64k).
REQ-010 sob SHALL be asserted on beat 0 only; eob, eof, error SHALL be driven on beat N-1 only, else 0/NO_ERRORS.
REQ-011 trace_bit, frame_bytes_in, last_frame SHALL be copied onto every beat.
REQ-012 States: EMPTY (no word held), BEAT0, BEAT1; EMPTY->BEAT0 on accept; BEAT0->BEAT1 on out handshake when N = 2; BEAT0/BEAT1->EMPTY on last-beat handshake with no new accept; last-beat handshake with simultaneous accept -> BEAT0.
REQ-013 in_ready SHALL be 1 in EMPTY, or combinationally out_ready on the last beat; otherwise 0.
REQ-014 Latency: out_valid SHALL rise the cycle after acceptance; throughput 1 beat/cycle with no bubbles between words.
REQ-015 out_valid SHALL be held with out_bus stable until out_ready; no beat dropped or duplicated.
REQ-016 in_numbits > 128 SHALL be clamped to 128 and flagged by simulation assertion.
REQ-017 in_numbits 1..63 without in_eob/in_eof SHALL be flagged by simulation assertion (only final partial word legal).
REQ-018 stall_stb SHALL be registered: 1 the cycle after out_valid && !out_ready && current beat trace_bit.

Reset
REQ-019 On rst_n low: state EMPTY, out_valid 0, out_bus 0, stall_stb 0, in_ready 1 after release.
REQ-020 Reset mid-word SHALL discard held word and remaining beats; no partial beat emitted after release.

Configuration
REQ-021 Macro CR_XP10_DECOMP_LANE_SPLIT_OUT_REG_EN SHALL insert an axi_channel_reg_slice (full handshake) on the out channel.
REQ-022 With macro defined: accept-to-out_valid latency 2 cycles, out_ready not combinationally fed to in_ready; throughput unchanged.
REQ-023 Without macro: latency 1 cycle, in_ready combinational from out_ready per REQ-013.

Structure
REQ-024 lfa_sdd_dp_bus_t and zipline_error_e SHALL come from cr_xp10_decompPKG; state enum SHALL be defined locally.
REQ-025 One sub-module: axi_channel_reg_slice, only under REQ-021; otherwise flat.

Verification
REQ-026 Word numbits=128, sob=1, out_ready=1 -> two beats numbits 64/64, sob on beat 0 only, in_ready low 1 cycle.
REQ-027 Word numbits=100, eob=1, errcode non-zero -> beats 64 then 36; eob and errcode on beat 1 only.
REQ-028 Word numbits=0, eof=1 -> single beat numbits 0, eof=1, sob as input.
REQ-029 Back-to-back full words, out_ready=1 -> continuous out_valid, 4 beats in 4 cycles, correct order.
REQ-030 out_ready low 3 cycles during beat 1, trace_bit=1 -> beat held stable, stall_stb high 3 cycles (delayed 1).
REQ-031 Assert rst_n during BEAT0 of 128-bit word -> out_valid 0 next cycle, no beat 1 after release; both macro settings.
